// File: rtl/adder_rr_arbiter_if.sv
// Handshake bundle between N_REQ requesters, the shared adder and the result consumer.
interface adder_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   sat_en;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH-1:0]       res_sum;
  logic                   res_carry;
  logic [ID_W-1:0]        res_id;
  logic [7:0]             busy_cnt;

  modport master (
    output req_valid, req_a, req_b, sat_en, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id, busy_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, sat_en, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id, busy_cnt
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin shared adder: one grant per cycle, result registered 1 cycle after grant.
// Grants stall (req_ready=0) while an unconsumed result is held under backpressure.
module adder_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  adder_rr_arbiter_if.slave  bus
);
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_carry;
  logic [ID_W-1:0]  r_res_id;
  logic [7:0]       r_busy_cnt;

  logic             w_can_accept;
  logic [N_REQ-1:0] w_grant;
  logic             w_found;
  logic [ID_W-1:0]  w_win_id;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum_full;
  logic [ID_W-1:0]  w_ptr_next;

  assign w_can_accept = !r_res_valid || bus.res_ready;

  // Scan starting at the pointer; the first valid requester wins.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_grant  = '0;
    w_found  = 1'b0;
    w_win_id = '0;
    v_idx    = '0;
    if (!rst && w_can_accept) begin
      for (int k = 0; k < N_REQ; k++) begin
        v_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
        if (!w_found && bus.req_valid[v_idx]) begin
          w_found         = 1'b1;
          w_grant[v_idx]  = 1'b1;
          w_win_id        = v_idx;
        end
      end
    end
  end

  assign w_a        = bus.req_a[int'(w_win_id)*WIDTH +: WIDTH];
  assign w_b        = bus.req_b[int'(w_win_id)*WIDTH +: WIDTH];
  assign w_sum_full = {1'b0, w_a} + {1'b0, w_b};
  assign w_ptr_next = (w_win_id == ID_W'(N_REQ-1)) ? '0 : w_win_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
      r_busy_cnt  <= '0;
    end else if (w_found) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= (bus.sat_en && w_sum_full[WIDTH]) ? {WIDTH{1'b1}} : w_sum_full[WIDTH-1:0];
      r_res_carry <= w_sum_full[WIDTH];
      r_res_id    <= w_win_id;
      r_rr_ptr    <= w_ptr_next;
      r_busy_cnt  <= r_busy_cnt + 8'd1;
    end else if (r_res_valid && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.res_valid = r_res_valid;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_carry = r_res_carry;
  assign bus.res_id    = r_res_id;
  assign bus.busy_cnt  = r_busy_cnt;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed plus randomized bench comparing adder_rr_arbiter against a rule-level model.
module tb_adder_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_rr_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();
  adder_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_valid, m_sum, m_carry, m_id, m_cnt, m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // Winner = valid requester at the smallest forward distance from the pointer.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int best, bestd, d;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (v[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v, input logic [31:0] av,
                      input logic [31:0] bv, input logic s, input logic rd,
                      output logic [N-1:0] got);
    int g, a, b, sum;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = r;
    bus.req_valid = v; bus.req_a = av; bus.req_b = bv;
    bus.sat_en = s; bus.res_ready = rd;
    #1;
    if (r) model_reset();
    g = (r || (m_valid != 0 && !rd)) ? -1 : pick(v, m_ptr);
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(bus.res_valid), m_valid);
    chk("res_sum",   32'(bus.res_sum),   m_sum);
    chk("res_carry", 32'(bus.res_carry), m_carry);
    chk("res_id",    32'(bus.res_id),    m_id);
    chk("busy_cnt",  32'(bus.busy_cnt),  m_cnt);
    got = bus.req_ready;
    @(posedge clk);
    if (!r) begin
      if (g >= 0) begin
        a = int'(av[g*W +: W]);
        b = int'(bv[g*W +: W]);
        sum = a + b;
        m_carry = (sum >= (1 << W)) ? 1 : 0;
        m_sum   = (s && m_carry != 0) ? (1 << W) - 1 : sum % (1 << W);
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % N;
        m_cnt   = (m_cnt + 1) % 256;
      end else if (m_valid != 0 && rd) begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] got;
    logic [N-1:0] seq [6];
    logic [31:0] av, bv;
    logic [W-1:0] frozen;
    model_reset();
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.sat_en = 1'b0; bus.res_ready = 1'b0;

    step(1, 4'b0000, 0, 0, 0, 0, got);
    step(1, 4'b0000, 0, 0, 0, 0, got);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_busy_cnt",  32'(bus.busy_cnt), 0);

    // Single request from 0
    step(0, 4'b0001, 32'h12, 32'h34, 0, 1, got);
    #1;
    chk("first_valid", 32'(bus.res_valid), 1);
    chk("first_sum",   32'(bus.res_sum), 32'h46);
    chk("first_carry", 32'(bus.res_carry), 0);
    chk("first_id",    32'(bus.res_id), 0);
    chk("first_cnt",   32'(bus.busy_cnt), 1);

    // Overflow with and without saturation
    step(0, 4'b0001, 32'hF0, 32'h20, 0, 1, got);
    #1;
    chk("ovf_sum",   32'(bus.res_sum), 32'h10);
    chk("ovf_carry", 32'(bus.res_carry), 1);
    step(0, 4'b0001, 32'hF0, 32'h20, 1, 1, got);
    #1;
    chk("sat_sum",   32'(bus.res_sum), 32'hFF);
    chk("sat_carry", 32'(bus.res_carry), 1);

    // Bring pointer back to 0, then all four requesting continuously
    step(0, 4'b1000, 32'h01000000, 32'h01000000, 0, 1, got);
    av = 32'h40302010; bv = 32'h04030201;
    for (int k = 0; k < 6; k++) begin
      step(0, 4'b1111, av, bv, 0, 1, got);
      seq[k] = got;
      #1;
      chk("rr_res_id", 32'(bus.res_id), k % 4);
      chk("rr_no_bubble", 32'(bus.res_valid), 1);
    end
    chk("rr_g0", 32'(seq[0]), 32'b0001);
    chk("rr_g1", 32'(seq[1]), 32'b0010);
    chk("rr_g2", 32'(seq[2]), 32'b0100);
    chk("rr_g3", 32'(seq[3]), 32'b1000);
    chk("rr_g4", 32'(seq[4]), 32'b0001);
    chk("rr_g5", 32'(seq[5]), 32'b0010);
    chk("rr_sum1", 32'(bus.res_sum), 32'h22);

    // One more grant to 0 leaves the pointer at 1; then hold backpressure
    step(0, 4'b0001, av, bv, 0, 1, got);
    #1;
    frozen = bus.res_sum;
    chk("bp_pre_sum", 32'(frozen), 32'h11);
    for (int k = 0; k < 3; k++) begin
      step(0, 4'b0110, av, bv, 0, 0, got);
      chk("bp_rdy_zero", 32'(got), 0);
      #1;
      chk("bp_frozen", 32'(bus.res_sum), 32'(frozen));
      chk("bp_valid", 32'(bus.res_valid), 1);
    end
    step(0, 4'b0110, av, bv, 0, 1, got);
    chk("bp_release_grant", 32'(got), 32'b0010);
    #1;
    chk("bp_release_valid", 32'(bus.res_valid), 1);
    chk("bp_release_id", 32'(bus.res_id), 1);

    // Last grant to 2, then 0 and 3 valid -> 3 first, then 0
    step(0, 4'b0100, av, bv, 0, 1, got);
    step(0, 4'b1001, av, bv, 0, 1, got);
    chk("fair_first", 32'(got), 32'b1000);
    step(0, 4'b1001, av, bv, 0, 1, got);
    chk("fair_second", 32'(got), 32'b0001);

    // Reset mid-operation with a pending result and requests waiting
    step(1, 4'b1111, av, bv, 0, 0, got);
    chk("midrst_rdy", 32'(got), 0);
    chk("midrst_valid", 32'(bus.res_valid), 0);
    step(0, 4'b1111, av, bv, 0, 1, got);
    chk("post_rst_grant", 32'(got), 32'b0001);
    #1;
    chk("post_rst_cnt", 32'(bus.busy_cnt), 1);

    // Randomized traffic, including rare resets and busy_cnt wrap
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 511) == 0), N'($urandom), $urandom, $urandom,
           1'($urandom), ($urandom_range(0, 3) != 0), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one WIDTH-bit adder (a + b, optional saturation) among N_REQ requesters.
- Each requester uses a valid/ready handshake; a round-robin arbiter grants one per cycle.
- Adder result is registered with the winner's ID and held under a valid/ready output handshake.
- Sits between requester ports and the top-level uo_out path; the single physical adder is the shared resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and sum width.
- ID_W, 2, width of requester ID; must equal clog2(N_REQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant (one-hot or zero); combinational.
- req_a  in  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, packed the same way.
- sat_en  in  1  1 = saturate sum to all-ones on carry out; sampled at grant.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  WIDTH  registered sum.
- res_carry  out  1  registered carry out of the unsaturated add.
- res_id  out  ID_W  index of the requester that produced the result.
- busy_cnt  out  8  count of accepted requests, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_sum=0, res_carry=0, res_id=0, busy_cnt=0, rr_ptr=0. req_ready is 0 while rst is high.
- can_accept = !res_valid || res_ready.
- Arbitration, combinational:
  - If can_accept, scan indices rr_ptr, rr_ptr+1, … mod N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other req_ready bits are 0.
  - If !can_accept, req_ready = 0.
- Transfer: a request transfers on a cycle with req_valid[i] && req_ready[i]. On that edge:
  - {res_carry, raw} = a_i + b_i, computed at WIDTH+1 bits.
  - res_sum = (sat_en && res_carry) ? all-ones : raw[WIDTH-1:0].
  - res_id = i, res_valid = 1.
  - rr_ptr = (i+1) mod N_REQ.
  - busy_cnt = busy_cnt + 1.
- Latency: result is visible the cycle after the grant.
- Throughput: one result per cycle when res_ready is held high.
- Output consume: if res_valid && res_ready and no new grant that cycle, res_valid goes to 0. res_sum, res_carry and res_id keep their last values.
- Simultaneous consume and grant: the new result overwrites the old one in the same edge and res_valid stays 1. No bubble, no loss.
- Backpressure: while res_valid=1 and res_ready=0:
  - Output registers are frozen.
  - All req_ready bits are 0.
  - rr_ptr is unchanged.
- No grant: if no request wins, rr_ptr is unchanged (pointer moves only on transfer).
- Requesters must hold a_i/b_i stable while req_valid is high and not yet granted. A dropped request is simply not granted. The arbiter imposes no fairness obligation for dropped requests.
- Starvation bound: a continuously asserted request is granted within N_REQ transfers.
- Reset mid-operation: a pending result is discarded, req_ready goes low immediately, and the pointer returns to 0.
- No combinational path from res_ready into res_sum, res_carry or res_id. req_ready may depend combinationally on res_ready.

Test Plan:
- Reset, then a single request from 0 with a=0x12, b=0x34, res_ready=1 -> next cycle res_valid=1, res_sum=0x46, res_carry=0, res_id=0, busy_cnt=1.
- Overflow: a=0xF0, b=0x20, sat_en=0 -> res_sum=0x10, res_carry=1. Same operands with sat_en=1 -> res_sum=0xFF, res_carry=1.
- All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows one cycle later; no idle cycles.
- Backpressure: res_ready=0 for 3 cycles with requesters 1 and 2 valid -> req_ready=0 and result frozen throughout. On res_ready=1 -> requester 1 is granted that cycle and res_valid stays high.
- Pointer fairness: requesters 0 and 3 valid after the last grant went to 2 -> 3 is granted first, then 0.
- Assert rst for 1 cycle while res_valid=1 and requests pending -> res_valid=0 and req_ready=0 during reset. After release, requester 0 has priority again and busy_cnt restarts from 0.
